// File: rtl/fx_result_pipe.sv
// Result pipeline and forwarding network for the SPU-Lite simple-fixed unit.
// Carries writing results through LATENCY stages and exposes every stage to three operand lookups.
module fx_result_pipe #(
  parameter int REG_ADDR_WD = 7,
  parameter int REG_DATA_WD = 128,
  parameter int LATENCY     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_reg_wr,
  input  logic [REG_ADDR_WD-1:0] in_RT_addr,
  input  logic [REG_DATA_WD-1:0] in_RT_data,
  input  logic                   flush,
  input  logic [REG_ADDR_WD-1:0] q_addr_RA,
  input  logic [REG_ADDR_WD-1:0] q_addr_RB,
  input  logic [REG_ADDR_WD-1:0] q_addr_RC,
  output logic                   q_hit_RA,
  output logic                   q_hit_RB,
  output logic                   q_hit_RC,
  output logic [REG_DATA_WD-1:0] q_data_RA,
  output logic [REG_DATA_WD-1:0] q_data_RB,
  output logic [REG_DATA_WD-1:0] q_data_RC,
  output logic                   wb_en,
  output logic [REG_ADDR_WD-1:0] wb_RT_addr,
  output logic [REG_DATA_WD-1:0] wb_RT_data,
  output logic                   busy
);

  // Index 0 is stage 1 (youngest), index LATENCY-1 is the writeback stage.
  logic                   v_q    [LATENCY];
  logic [REG_ADDR_WD-1:0] addr_q [LATENCY];
  logic [REG_DATA_WD-1:0] data_q [LATENCY];
  logic                   v_d    [LATENCY];
  logic [REG_ADDR_WD-1:0] addr_d [LATENCY];
  logic [REG_DATA_WD-1:0] data_d [LATENCY];

  always_comb begin
    v_d[0]    = in_valid & in_reg_wr & ~flush;
    addr_d[0] = in_RT_addr;
    data_d[0] = in_RT_data;
    for (int k = 1; k < LATENCY; k++) begin
      v_d[k]    = v_q[k-1] & ~flush;
      addr_d[k] = addr_q[k-1];
      data_d[k] = data_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        v_q[k]    <= 1'b0;
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LATENCY; k++) begin
        v_q[k]    <= v_d[k];
        addr_q[k] <= addr_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  // ---- stage LATENCY boundary: writeback and forwarding ----
  assign wb_en      = v_q[LATENCY-1];
  assign wb_RT_addr = addr_q[LATENCY-1];
  assign wb_RT_data = data_q[LATENCY-1];

  logic [REG_ADDR_WD-1:0] qa  [3];
  logic                   hit [3];
  logic [REG_DATA_WD-1:0] fwd [3];
  logic                   busy_c;

  assign qa[0] = q_addr_RA;
  assign qa[1] = q_addr_RB;
  assign qa[2] = q_addr_RC;

  // Scan oldest to youngest so the youngest hitting stage overrides.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      hit[p] = 1'b0;
      fwd[p] = '0;
      for (int k = LATENCY-1; k >= 0; k--) begin
        if (v_q[k] && (addr_q[k] == qa[p])) begin
          hit[p] = 1'b1;
          fwd[p] = data_q[k];
        end
      end
    end
  end

  always_comb begin
    busy_c = 1'b0;
    for (int k = 0; k < LATENCY; k++) busy_c = busy_c | v_q[k];
  end

  assign busy      = busy_c;
  assign q_hit_RA  = hit[0];
  assign q_hit_RB  = hit[1];
  assign q_hit_RC  = hit[2];
  assign q_data_RA = fwd[0];
  assign q_data_RB = fwd[1];
  assign q_data_RC = fwd[2];

endmodule
